// File: rtl/multicycle_control_if.sv
// Handshake/strobe bundle between the multicycle controller and its datapath.
//   opcode, equal, mem_ready, alu_done : datapath -> controller
//   IRWr .. MemRd, ALUctr              : datapath strobes from controller
//   alu_start, retire, illegal, timeout: single-cycle event pulses
// slave modport is the controller's view, master the datapath's.
interface multicycle_control_if #(
    parameter int OPW  = 6,
    parameter int ALUW = 3
);
    logic [OPW-1:0]  opcode;
    logic            equal;
    logic            mem_ready;
    logic            alu_done;
    logic            IRWr;
    logic            PCWr;
    logic            nPC_sel;
    logic            RegDst;
    logic            AluSrc;
    logic            MemtoReg;
    logic            RegWr;
    logic            MemWr;
    logic            MemRd;
    logic [ALUW-1:0] ALUctr;
    logic            alu_start;
    logic            retire;
    logic            illegal;
    logic            timeout;

    modport slave (
        input  opcode, equal, mem_ready, alu_done,
        output IRWr, PCWr, nPC_sel, RegDst, AluSrc, MemtoReg, RegWr, MemWr,
               MemRd, ALUctr, alu_start, retire, illegal, timeout
    );

    modport master (
        output opcode, equal, mem_ready, alu_done,
        input  IRWr, PCWr, nPC_sel, RegDst, AluSrc, MemtoReg, RegWr, MemWr,
               MemRd, ALUctr, alu_start, retire, illegal, timeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle processor control unit: fetch/decode/execute sequencing with
// memory wait states and a timed long-latency ALU path.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : multicycle_control_if.slave (opcode/flags in, strobes/pulses out)
//
// state  | meaning
// FETCH  | read instruction memory, wait for mem_ready, load IR and PC+4
// DECODE | latch opcode, dispatch or flag illegal
// ADDR   | compute effective address for lw/sw
// MEMRD  | data memory read, wait for mem_ready
// WBMEM  | write loaded data to register file, retire
// MEMWR  | data memory write, wait for mem_ready, retire
// BRANCH | compare, conditionally take branch, retire
// EXEC   | single-cycle add/sub
// LONG   | multicycle mul/div/float, wait for alu_done or timeout
// WBALU  | write ALU result to register file, retire
module multicycle_control #(
    parameter int OPW  = 6,
    parameter int ALUW = 3,
    parameter int TOW  = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.slave  bus
);

    typedef enum logic [3:0] {
        FETCH, DECODE, ADDR, MEMRD, WBMEM, MEMWR, BRANCH, EXEC, LONG, WBALU
    } state_t;

    localparam logic [OPW-1:0] OP_SW  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4);
    localparam logic [OPW-1:0] OP_MUL = OPW'(5);
    localparam logic [OPW-1:0] OP_DIV = OPW'(6);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [TOW-1:0] cnt;

    logic legal;
    logic cnt_last;

    // Legal opcodes use only the low three bits.
    assign legal    = ((bus.opcode >> 3) == '0);
    assign cnt_last = (cnt == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            op_q  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                FETCH:  if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    op_q <= bus.opcode;
                    cnt  <= '0;
                    if (!legal) begin
                        state <= FETCH;
                    end else begin
                        case (bus.opcode[2:0])
                            3'd0, 3'd1: state <= ADDR;
                            3'd2:       state <= BRANCH;
                            3'd3, 3'd4: state <= EXEC;
                            default:    state <= LONG;
                        endcase
                    end
                end
                ADDR:   state <= (op_q == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (bus.mem_ready) state <= WBMEM;
                WBMEM:  state <= FETCH;
                MEMWR:  if (bus.mem_ready) state <= FETCH;
                BRANCH: state <= FETCH;
                EXEC:   state <= WBALU;
                LONG: begin
                    // alu_done takes priority over an expiring timer
                    if (bus.alu_done)  state <= WBALU;
                    else if (cnt_last) state <= FETCH;
                    else               cnt   <= cnt + 1'b1;
                end
                WBALU:  state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    logic            irwr, pcwr, npc_sel, regdst, alusrc, memtoreg;
    logic            regwr, memwr, memrd, start, ret, ill, tout;
    logic [ALUW-1:0] aluctr;

    always_comb begin
        irwr     = 1'b0;
        pcwr     = 1'b0;
        npc_sel  = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        regwr    = 1'b0;
        memwr    = 1'b0;
        memrd    = 1'b0;
        start    = 1'b0;
        ret      = 1'b0;
        ill      = 1'b0;
        tout     = 1'b0;
        aluctr   = '0;
        case (state)
            FETCH: begin
                memrd = 1'b1;
                irwr  = bus.mem_ready;
                pcwr  = bus.mem_ready;
            end
            DECODE: ill = !legal;
            ADDR:   alusrc = 1'b1;
            MEMRD: begin
                memrd  = 1'b1;
                alusrc = 1'b1;
            end
            WBMEM: begin
                regwr    = 1'b1;
                memtoreg = 1'b1;
                ret      = 1'b1;
            end
            MEMWR: begin
                memwr  = 1'b1;
                alusrc = 1'b1;
                ret    = bus.mem_ready;
            end
            BRANCH: begin
                aluctr  = ALUW'(3'b001);
                pcwr    = bus.equal;
                npc_sel = bus.equal;
                ret     = 1'b1;
            end
            EXEC: aluctr = (op_q == OP_SUB) ? ALUW'(3'b001) : ALUW'(3'b000);
            LONG: begin
                if (op_q == OP_MUL)      aluctr = ALUW'(3'b010);
                else if (op_q == OP_DIV) aluctr = ALUW'(3'b100);
                else                     aluctr = ALUW'(3'b110);
                // counter is zero only on the entry cycle
                start = (cnt == '0);
                tout  = cnt_last && !bus.alu_done;
            end
            WBALU: begin
                regwr  = 1'b1;
                regdst = 1'b1;
                ret    = 1'b1;
            end
            default: ;
        endcase
    end

    // While reset is held only the FETCH read strobe may show.
    assign bus.IRWr      = irwr     & rst_n;
    assign bus.PCWr      = pcwr     & rst_n;
    assign bus.nPC_sel   = npc_sel  & rst_n;
    assign bus.RegDst    = regdst   & rst_n;
    assign bus.AluSrc    = alusrc   & rst_n;
    assign bus.MemtoReg  = memtoreg & rst_n;
    assign bus.RegWr     = regwr    & rst_n;
    assign bus.MemWr     = memwr    & rst_n;
    assign bus.MemRd     = memrd;
    assign bus.ALUctr    = aluctr & {ALUW{rst_n}};
    assign bus.alu_start = start & rst_n;
    assign bus.retire    = ret   & rst_n;
    assign bus.illegal   = ill   & rst_n;
    assign bus.timeout   = tout  & rst_n;

endmodule
